// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, FSM states and ALU encoding for multi_cycle_cpu
package cpu_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // The all-zero word decodes as an R-type whose result lands in reg 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    function automatic logic instr_legal(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        if (instr == NOP_INSTR) begin
            return 1'b1;
        end
        if (op == OP_RTYPE) begin
            return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                   (fn == FN_OR)  || (fn == FN_SLT);
        end
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J)  || (op == OP_ADDI);
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// rtl/cpu_alu.sv - combinational add/sub/and/or/slt ALU with zero flag
//   a_i, b_i : operands
//   op_i     : alu_op_e operation select
//   res_o    : result (wraps mod 2^32)
//   zero_o   : res_o == 0
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] res_o,
    output logic        zero_o
);

    always_comb begin
        res_o = a_i + b_i;
        case (op_i)
            ALU_SUB: res_o = a_i - b_i;
            ALU_AND: res_o = a_i & b_i;
            ALU_OR:  res_o = a_i | b_i;
            ALU_SLT: res_o = {31'd0, $signed(a_i) < $signed(b_i)};
            default: res_o = a_i + b_i;
        endcase
    end

    assign zero_o = (res_o == 32'd0);

endmodule

// File: rtl/multi_cycle_cpu.sv
// rtl/multi_cycle_cpu.sv - multi-cycle MIPS-subset core with shared req/ready memory port
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   mem_req/we/addr/wdata, mem_rdata/ready : single shared instruction/data port
//   pc_out              : address of the instruction in flight
//   halt                : core stopped on an illegal instruction
//   dbg_raddr/dbg_rdata : combinational register-file read port
//   cycle_cnt/instr_cnt : perf counters, present only when CPU_PERF_CNT_EN is defined
module multi_cycle_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef CPU_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_out,
    output logic              halt,
    input  logic [4:0]        dbg_raddr,
    output logic [31:0]       dbg_rdata
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
`endif
);

    state_e              state_q;
    logic [31:0]         pc_q, instr_pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic                mem_req_q, mem_we_q, halt_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [31:0]         rf_q [32];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, wb_idx;
    logic [31:0] imm_sext, alu_b, alu_res, pc_exec_d, wb_data;
    logic        is_rtype, alu_zero;
    alu_op_e     alu_op;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign is_rtype = (op == OP_RTYPE);

    // beq compares through the subtractor; everything that is not R-type uses the immediate.
    assign alu_b  = (is_rtype || op == OP_BEQ) ? b_q : imm_sext;
    assign alu_op = is_rtype ? funct_to_alu(ir_q[5:0]) : ((op == OP_BEQ) ? ALU_SUB : ALU_ADD);

    cpu_alu u_alu (
        .a_i    (a_q),
        .b_i    (alu_b),
        .op_i   (alu_op),
        .res_o  (alu_res),
        .zero_o (alu_zero)
    );

    // pc_q already points past the current instruction when EXEC runs.
    always_comb begin
        pc_exec_d = pc_q;
        if (op == OP_BEQ && alu_zero) begin
            pc_exec_d = pc_q + {imm_sext[29:0], 2'b00};
        end else if (op == OP_J) begin
            pc_exec_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        end
    end

    // Outputs are registered, so a fetch is pre-armed when leaving EXEC/WB. After a
    // store, or out of reset, the first FETCH cycle only raises mem_req, which keeps
    // an idle bus cycle between back-to-back transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_pc_q  <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halt_q      <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q[ADDR_W-1:0];
                    end else if (mem_ready) begin
                        ir_q       <= mem_rdata;
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        mem_req_q  <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rf_q[rs];
                    b_q <= rf_q[rt];
                    if (!instr_legal(ir_q)) begin
                        halt_q  <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_LW, OP_SW: begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (op == OP_SW);
                            mem_addr_q  <= {alu_res[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= b_q;
                            state_q     <= S_MEM;
                        end
                        OP_BEQ, OP_J: begin
                            pc_q       <= pc_exec_d;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pc_exec_d[ADDR_W-1:0];
                            state_q    <= S_FETCH;
                        end
                        default: begin
                            alu_q   <= alu_res;
                            state_q <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (op == OP_LW) begin
                            mdr_q   <= mem_rdata;
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_q[ADDR_W-1:0];
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign wb_idx  = is_rtype ? rd : rt;
    assign wb_data = (op == OP_LW) ? mdr_q : alu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (state_q == S_WB && wb_idx != 5'd0) begin
            rf_q[wb_idx] <= wb_data;
        end
    end

    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf_q[dbg_raddr];
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halt      = halt_q;
    assign pc_out    = (state_q == S_FETCH) ? pc_q : instr_pc_q;

`ifdef CPU_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
    logic             instr_done;

    // Completion is any transition back into FETCH.
    assign instr_done = (state_q == S_EXEC && (op == OP_BEQ || op == OP_J)) ||
                        (state_q == S_MEM && mem_ready && op != OP_LW) ||
                        (state_q == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if (instr_done) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
